// File: rtl/hash_candidate_requester.sv
// -----------------------------------------------------------------------------
// hash_candidate_requester
//
// Read-side client of the match engine's hash handshake buffer. For every
// position of a job it holds a read request, captures the returned row of
// ROW_SIZE candidate history addresses, and serialises the valid candidates
// one per beat to the downstream match PE. Skip-ahead commands from the PE
// advance the position by more than one and flush the remaining candidates.
//
// Optional feature (compile-time macro HASH_REQ_WINDOW_FILTER_EN):
//   defined   - at capture, a slot is also dropped when its history address is
//               not strictly behind the current position or lies more than
//               WINDOW_SIZE bytes back.
//   undefined - the captured mask is read_valid_array unchanged.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   job_valid/job_ready        job command handshake (ready only when idle)
//   job_start_addr/end_addr    first position / exclusive end position
//   read_req_valid/addr        request held to the buffer for one position
//   read_resp_valid/addr       buffer response and the position it belongs to
//   read_valid_array           per-slot candidate valid
//   read_history_addr_array    slot i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
//   cand_valid/cand_ready      candidate beat handshake
//   cand_cur_addr              position the beat belongs to
//   cand_hist_addr             candidate history address (0 on cand_none)
//   cand_none                  position has no candidate (single beat)
//   cand_last                  final beat of this position
//   skip_valid/skip_len        skip-ahead command from the PE
//   job_done                   one-cycle pulse when the job finishes
// -----------------------------------------------------------------------------
module hash_candidate_requester #(
    parameter int ROW_SIZE    = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int WINDOW_SIZE = 65536
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           job_valid,
    input  logic [ADDR_WIDTH-1:0]          job_start_addr,
    input  logic [ADDR_WIDTH-1:0]          job_end_addr,
    output logic                           job_ready,
    output logic                           read_req_valid,
    output logic [ADDR_WIDTH-1:0]          read_req_addr,
    input  logic                           read_resp_valid,
    input  logic [ADDR_WIDTH-1:0]          read_resp_addr,
    input  logic [ROW_SIZE-1:0]            read_valid_array,
    input  logic [ROW_SIZE*ADDR_WIDTH-1:0] read_history_addr_array,
    output logic                           cand_valid,
    input  logic                           cand_ready,
    output logic [ADDR_WIDTH-1:0]          cand_cur_addr,
    output logic [ADDR_WIDTH-1:0]          cand_hist_addr,
    output logic                           cand_none,
    output logic                           cand_last,
    input  logic                           skip_valid,
    input  logic [ADDR_WIDTH-1:0]          skip_len,
    output logic                           job_done
);

    if (WINDOW_SIZE < 1 || ROW_SIZE < 1) begin : g_param_check
        $error("hash_candidate_requester: WINDOW_SIZE and ROW_SIZE must be positive");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           cur_q, cur_d;
    logic [ADDR_WIDTH-1:0]           end_q, end_d;
    logic [ADDR_WIDTH-1:0]           pend_q, pend_d;
    logic                            flush_q, flush_d;
    logic                            req_prev_q, req_prev_d;
    logic [ADDR_WIDTH-1:0]           req_addr_prev_q, req_addr_prev_d;
    logic                            job_done_q, job_done_d;
    logic [ROW_SIZE-1:0]             mask_q, mask_d;
    logic [ROW_SIZE*ADDR_WIDTH-1:0]  row_q, row_d;

    logic [ROW_SIZE-1:0]             low_bit;
    logic [ROW_SIZE-1:0]             rem_mask;
    logic [ROW_SIZE-1:0]             capture_mask;
    logic [ADDR_WIDTH-1:0]           sel_hist;
    logic [ADDR_WIDTH-1:0]           skip_len_eff;
    logic [ADDR_WIDTH-1:0]           pend_merged;
    logic [ADDR_WIDTH-1:0]           step;
    logic [ADDR_WIDTH:0]             next_pos;
    logic                            past_end;
    logic                            resp_accept;
    logic                            natural_last;
    logic                            beat;

    function automatic logic [ADDR_WIDTH-1:0] max_len(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [ADDR_WIDTH-1:0] b);
        return (a > b) ? a : b;
    endfunction

`ifdef HASH_REQ_WINDOW_FILTER_EN
    function automatic logic [ROW_SIZE-1:0] window_filter(
        input logic [ROW_SIZE-1:0]            mask,
        input logic [ROW_SIZE*ADDR_WIDTH-1:0] row,
        input logic [ADDR_WIDTH-1:0]          cur
    );
        logic [ROW_SIZE-1:0]   keep;
        logic [ADDR_WIDTH-1:0] hist;
        logic [ADDR_WIDTH-1:0] dist;
        keep = mask;
        for (int i = 0; i < ROW_SIZE; i++) begin
            hist = row[i*ADDR_WIDTH +: ADDR_WIDTH];
            dist = cur - hist;
            // Only strictly-earlier positions within the window are legal.
            if (hist >= cur || 64'(dist) > 64'(WINDOW_SIZE)) begin
                keep[i] = 1'b0;
            end
        end
        return keep;
    endfunction

    assign capture_mask = window_filter(read_valid_array, read_history_addr_array, cur_q);
`else
    assign capture_mask = read_valid_array;
`endif

    // Lowest remaining slot is isolated as a one-hot; the rest is what stays
    // after this beat is accepted.
    assign low_bit      = mask_q & (~mask_q + ROW_SIZE'(1));
    assign rem_mask     = mask_q & ~low_bit;
    assign natural_last = (rem_mask == '0);

    always_comb begin
        sel_hist = '0;
        for (int i = 0; i < ROW_SIZE; i++) begin
            if (low_bit[i]) begin
                sel_hist = sel_hist | row_q[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // A skip in the current cycle is folded into the step so that a skip
    // coinciding with the final handshake still takes effect.
    assign skip_len_eff = (skip_len == '0) ? ADDR_WIDTH'(1) : skip_len;
    assign pend_merged  = skip_valid ? max_len(pend_q, skip_len_eff) : pend_q;
    assign step         = (pend_merged == '0) ? ADDR_WIDTH'(1) : pend_merged;
    assign next_pos     = {1'b0, cur_q} + {1'b0, step};
    assign past_end     = (next_pos >= {1'b0, end_q});

    // The request must already have been visible for a full cycle at this
    // address, otherwise the response may be a registered leftover from the
    // previous position.
    assign resp_accept = (state_q == REQ) && read_resp_valid && (read_resp_addr == cur_q) &&
                         req_prev_q && (req_addr_prev_q == cur_q);

    assign beat = (state_q == EMIT) && cand_ready;

    always_comb begin
        state_d         = state_q;
        cur_d           = cur_q;
        end_d           = end_q;
        pend_d          = pend_q;
        flush_d         = flush_q;
        mask_d          = mask_q;
        row_d           = row_q;
        job_done_d      = 1'b0;
        req_prev_d      = (state_q == REQ);
        req_addr_prev_d = cur_q;

        case (state_q)
            IDLE: begin
                if (job_valid) begin
                    cur_d = job_start_addr;
                    end_d = job_end_addr;
                    if (job_start_addr >= job_end_addr) begin
                        job_done_d = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end

            REQ: begin
                pend_d = pend_merged;
                if (resp_accept) begin
                    mask_d  = capture_mask;
                    row_d   = read_history_addr_array;
                    flush_d = 1'b0;
                    state_d = EMIT;
                end
            end

            EMIT: begin
                pend_d = pend_merged;
                if (beat) begin
                    mask_d = rem_mask;
                    if (natural_last || flush_q || skip_valid) begin
                        pend_d  = '0;
                        flush_d = 1'b0;
                        if (past_end) begin
                            job_done_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            cur_d   = next_pos[ADDR_WIDTH-1:0];
                            state_d = REQ;
                        end
                    end
                end else if (skip_valid) begin
                    // Current beat becomes the final one of this position.
                    flush_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cur_q           <= '0;
            end_q           <= '0;
            pend_q          <= '0;
            flush_q         <= 1'b0;
            req_prev_q      <= 1'b0;
            req_addr_prev_q <= '0;
            job_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_q           <= cur_d;
            end_q           <= end_d;
            pend_q          <= pend_d;
            flush_q         <= flush_d;
            req_prev_q      <= req_prev_d;
            req_addr_prev_q <= req_addr_prev_d;
            job_done_q      <= job_done_d;
        end
    end

    // Captured row data is only observed in EMIT, so it needs no reset.
    always_ff @(posedge clk) begin
        mask_q <= mask_d;
        row_q  <= row_d;
    end

    assign job_ready      = (state_q == IDLE);
    assign read_req_valid = (state_q == REQ);
    assign read_req_addr  = (state_q == REQ) ? cur_q : '0;
    assign cand_valid     = (state_q == EMIT);
    assign cand_cur_addr  = (state_q == EMIT) ? cur_q : '0;
    assign cand_hist_addr = (state_q == EMIT) ? sel_hist : '0;
    assign cand_none      = (state_q == EMIT) && (mask_q == '0);
    assign cand_last      = (state_q == EMIT) && (natural_last || flush_q);
    assign job_done       = job_done_q;

endmodule

// File: doc/hash_candidate_requester.md
Name: hash_candidate_requester

Overview:
- Read-side client of the match engine's hash handshake buffer.
- Walks a job's position range, holds a read request per position, and captures the buffer's row of ROW_SIZE candidate history addresses.
- Serialises the valid candidates one per beat to the downstream match PE.
- Honours skip-ahead commands from the PE after a match.

Parameters:
ROW_SIZE, `ROW_SIZE, candidate slots per hashed position
ADDR_WIDTH, `ADDR_WIDTH, byte-address width
WINDOW_SIZE, 65536, maximum legal match distance (used only by the optional feature)

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
job_valid  input  1  job command valid
job_start_addr  input  ADDR_WIDTH  first position of job
job_end_addr  input  ADDR_WIDTH  exclusive end position
job_ready  output  1  high only in IDLE
read_req_valid  output  1  request to buffer
read_req_addr  output  ADDR_WIDTH  requested position
read_resp_valid  input  1  buffer response valid
read_resp_addr  input  ADDR_WIDTH  position of response
read_valid_array  input  ROW_SIZE  per-slot candidate valid
read_history_addr_array  input  ROW_SIZE*ADDR_WIDTH  slot i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
cand_valid  output  1  candidate beat valid
cand_ready  input  1  downstream accept
cand_cur_addr  output  ADDR_WIDTH  current position
cand_hist_addr  output  ADDR_WIDTH  candidate history address (0 when cand_none)
cand_none  output  1  position has no valid candidate (single beat)
cand_last  output  1  final beat of this position
skip_valid  input  1  skip-ahead pulse
skip_len  input  ADDR_WIDTH  positions to advance
job_done  output  1  one-cycle pulse at job end

Behaviour:
- Reset (async): state=IDLE, job_ready=1, read_req_valid=0, read_req_addr=0, cand_valid=0, cand_none=0, cand_last=0, cand_cur_addr=0, cand_hist_addr=0, job_done=0; pending skip cleared.
- IDLE: on job_valid&&job_ready, latch cur=job_start_addr and end=job_end_addr.
  - If start>=end: pulse job_done next cycle and stay IDLE.
  - Else go to REQ.
- REQ:
  - read_req_valid=1, read_req_addr=cur, held stable.
  - A response is accepted only if read_resp_valid && read_resp_addr==cur && read_req_valid was already high with the same address in the previous cycle. This rejects stale registered responses.
  - On accept: latch mask and history row, go to EMIT, drop read_req_valid.
  - Minimum REQ→EMIT latency: 2 cycles after entering REQ.
  - Waiting is unbounded; the buffer may be refilling.
- EMIT:
  - cand_valid=1. Slot = lowest set bit of the remaining mask; cand_hist_addr = that slot's address.
  - cand_last=1 when no other bit remains.
  - On cand_valid&&cand_ready: clear that bit.
  - Empty mask: emit one beat with cand_none=1, cand_last=1.
  - Outputs stable while cand_ready=0.
- Position advance, after the handshake of the last beat:
  - step = max(1, pending_skip); cur += step; pending cleared.
  - Computed in ADDR_WIDTH+1 bits. If the result >= end (including overflow): job_done pulses the next cycle, go to IDLE. Otherwise go to REQ.
- Skip:
  - skip_valid is sampled in REQ and EMIT; pending_skip = max(pending_skip, skip_len).
  - skip_valid in EMIT also flushes the remaining candidates: the current beat is the last one accepted, and advance occurs on its handshake, or immediately if cand_valid is already finished.
  - skip_len=0 is treated as 1.
  - skip_valid in IDLE is ignored.
- Simultaneous events:
  - Skip and final handshake in the same cycle: the skip is included in that cycle's step.
  - job_valid during busy: not accepted (job_ready=0).

Optional Feature:
HASH_REQ_WINDOW_FILTER_EN
- Defined: at capture, slot i's valid is additionally cleared if hist>=cur or cur-hist>WINDOW_SIZE. This costs no extra latency; a fully filtered row produces a cand_none beat.
- Undefined: the captured mask equals read_valid_array unchanged.

Test Plan:
- Job 0x10..0x12, buffer returns mask 0b0101 (ROW_SIZE=4) with hist 0x3,_,0x8,_ → beats (0x10,0x3,last=0), (0x10,0x8,last=1), then REQ 0x11; done pulse after position 0x11.
- Stale response: resp_valid=1 with addr=0x10 on the first REQ cycle for 0x10 → ignored; the accept occurs only on the following cycle.
- Mask 0 → single beat cand_none=1, cand_last=1, cand_hist_addr=0.
- cand_ready held low 5 cycles mid-row → outputs constant; no beat lost or duplicated.
- skip_valid with skip_len=7 on the first beat of position 0x20 (mask 3 bits) → that beat is the last consumed; next read_req_addr=0x27.
- Window filter on, cur=0x100, hist 0x100 and 0x80 → 0x100 dropped, 0x80 emitted. With the macro off, both are emitted.
- rst_n asserted while in EMIT → outputs clear asynchronously; job_ready=1 after release.
